cpu_controller: RTL and testbench

- Instruction register, decoder and control FSM for the 5-step RISC machine.
- Latches a 16-bit instruction and, on a start handshake, sequences it through the datapath.
- Drives the datapath's register-file, pipeline-register, mux, shifter and ALU controls, and its sign-extended immediates.
- Sits above the datapath; controls only, no data path of its own.

---
 rtl/cpu_controller.sv | 170 +++++++++++++++++
 tb/tb_cpu_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// cpu_controller: instruction register, decoder and control FSM for the
// 5-step RISC machine. Every control output is a flip-flop, so the datapath
// can safely gate its register clocks with these enables.
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  typedef struct packed {
    logic       w;
    logic       write;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic [1:0] shift;
    logic [1:0] alu_op;
  } ctrl_t;

  // Idle word: only w is high.
  localparam ctrl_t CTRL_IDLE = ctrl_t'({1'b1, {($bits(ctrl_t) - 1){1'b0}}});

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  ctrl_t       ctrl_q, ctrl_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;
  logic       is_movi, is_movr, is_add, is_cmp, is_and, is_mvn;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_add  = (opcode == 3'b101) && (op == 2'b00);
  assign is_cmp  = (opcode == 3'b101) && (op == 2'b01);
  assign is_and  = (opcode == 3'b101) && (op == 2'b10);
  assign is_mvn  = (opcode == 3'b101) && (op == 2'b11);

  // The IR only accepts a new word while idle, so a running instruction is never disturbed.
  always_comb begin
    ir_d = ir_q;
    if ((state_q == S_WAIT) && load) ir_d = in;
  end

  // Next-state sequencing; unsupported encodings fall straight back to WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:      if (s) state_d = S_DECODE;
      S_DECODE: begin
        if (is_movi)                           state_d = S_WRITE_IMM;
        else if (is_add || is_cmp || is_and)   state_d = S_GET_A;
        else if (is_movr || is_mvn)            state_d = S_GET_B;
        else                                   state_d = S_WAIT;
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  // Control word for the state being entered, registered on the same edge as the state.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_WAIT:      ctrl_d.w = 1'b1;
      S_WRITE_IMM: begin
        ctrl_d.write    = 1'b1;
        ctrl_d.writenum = rn;
        ctrl_d.vsel     = 2'b10;
      end
      S_GET_A: begin
        ctrl_d.readnum = rn;
        ctrl_d.loada   = 1'b1;
      end
      S_GET_B: begin
        ctrl_d.readnum = rm;
        ctrl_d.loadb   = 1'b1;
      end
      S_ALU: begin
        ctrl_d.shift  = sh;
        ctrl_d.alu_op = is_movr ? 2'b00 : op;
        ctrl_d.asel   = is_movr;
        ctrl_d.loads  = is_cmp;
        ctrl_d.loadc  = ~is_cmp;
      end
      S_WRITE_REG: begin
        ctrl_d.write    = 1'b1;
        ctrl_d.writenum = rd;
        ctrl_d.vsel     = 2'b00;
      end
      default: ctrl_d = '0;
    endcase
  end

  // State, IR and registered control outputs; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      ctrl_q  <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign w        = ctrl_q.w;
  assign write    = ctrl_q.write;
  assign vsel     = ctrl_q.vsel;
  assign loada    = ctrl_q.loada;
  assign loadb    = ctrl_q.loadb;
  assign loadc    = ctrl_q.loadc;
  assign loads    = ctrl_q.loads;
  assign asel     = ctrl_q.asel;
  assign bsel     = ctrl_q.bsel;
  assign readnum  = ctrl_q.readnum;
  assign writenum = ctrl_q.writenum;
  assign shift    = ctrl_q.shift;
  assign ALUop    = ctrl_q.alu_op;

  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: a step-list model of each instruction
// queues the expected control word of every cycle; a negedge monitor pops and
// compares while the controller is busy and on its first idle cycle.
module tb_cpu_controller;

  typedef struct packed {
    logic        w;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
  } word_t;

  logic        clk, reset, s, load;
  logic [15:0] in_r;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, shift, ALUop;
  logic [2:0]  readnum, writenum;
  logic [15:0] sximm8, sximm5;

  word_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  logic  prev_w = 1'b1;

  cpu_controller dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in_r),
    .w(w), .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .readnum(readnum), .writenum(writenum), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic word_t actual();
    word_t a;
    a = '{w: w, write: write, vsel: vsel, loada: loada, loadb: loadb,
          loadc: loadc, loads: loads, asel: asel, bsel: bsel,
          readnum: readnum, writenum: writenum, shift: shift, aluop: ALUop,
          sximm8: sximm8, sximm5: sximm5};
    return a;
  endfunction

  function automatic logic [15:0] sext(input int value, input int bits);
    int v;
    v = value % (1 << bits);
    if (v >= (1 << (bits - 1))) v = v - (1 << bits);
    return 16'(v);
  endfunction

  // Reference model: build the cycle-by-cycle step list for one execution.
  task automatic expect_instr(input logic [15:0] ir, output int busy_len);
    int    opc, opx;
    string kind;
    word_t base, e;
    opc = int'(ir[15:13]);
    opx = int'(ir[12:11]);
    if (opc == 6 && opx == 2)      kind = "MOVI";
    else if (opc == 6 && opx == 0) kind = "MOVR";
    else if (opc == 5 && opx == 0) kind = "ADD";
    else if (opc == 5 && opx == 1) kind = "CMP";
    else if (opc == 5 && opx == 2) kind = "AND";
    else if (opc == 5 && opx == 3) kind = "MVN";
    else                           kind = "ILL";
    base = '0;
    base.sximm8 = sext(int'(ir[7:0]), 8);
    base.sximm5 = sext(int'(ir[4:0]), 5);
    busy_len = 0;
    exp_q.push_back(base); busy_len++;               // decode cycle
    if (kind == "MOVI") begin
      e = base; e.write = 1; e.writenum = ir[10:8]; e.vsel = 2'b10;
      exp_q.push_back(e); busy_len++;
    end else if (kind != "ILL") begin
      if (kind == "ADD" || kind == "CMP" || kind == "AND") begin
        e = base; e.readnum = ir[10:8]; e.loada = 1;
        exp_q.push_back(e); busy_len++;
      end
      e = base; e.readnum = ir[2:0]; e.loadb = 1;
      exp_q.push_back(e); busy_len++;
      e = base; e.shift = ir[4:3];
      e.aluop = (kind == "MOVR") ? 2'b00 : ir[12:11];
      e.asel  = (kind == "MOVR");
      e.loads = (kind == "CMP");
      e.loadc = (kind != "CMP");
      exp_q.push_back(e); busy_len++;
      if (kind != "CMP") begin
        e = base; e.write = 1; e.writenum = ir[7:5];
        exp_q.push_back(e); busy_len++;
      end
    end
    e = base; e.w = 1;
    exp_q.push_back(e);                               // first idle cycle
  endtask

  task automatic check_word(input string name, input word_t a, input word_t e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, a, e);
    end
  endtask

  task automatic check_bit(input string name, input logic a, input logic e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %b required %b", name, a, e);
    end
  endtask

  // Monitor: compare every busy cycle and the idle cycle that follows it.
  always @(negedge clk) begin
    word_t e;
    if (reset) begin
      prev_w = 1'b1;
    end else begin
      if (!w || !prev_w) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_cycle: got %h required no activity", actual());
        end else begin
          e = exp_q.pop_front();
          check_word("cycle_word", actual(), e);
        end
      end
      prev_w = w;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (w !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 30) begin
      n_vec++; n_err++;
      $display("FAIL wait_idle: got w=%b after %0d cycles required w=1", w, n);
    end
  endtask

  task automatic load_ir(input logic [15:0] ir);
    load = 1'b1; in_r = ir;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Start with s held for n back-to-back executions of the current IR.
  task automatic exec(input logic [15:0] ir, input int n);
    int len;
    for (int i = 0; i < n; i++) expect_instr(ir, len);
    s = 1'b1;
    @(posedge clk);
    repeat ((n - 1) * (len + 1)) @(posedge clk);
    #1 s = 1'b0;
    wait_idle();
    @(posedge clk); #1;
  endtask

  initial begin
    word_t idle0;
    int    len;
    logic [15:0] ir;
    logic [2:0]  op3;
    int    r;

    reset = 1'b1; s = 1'b0; load = 1'b0; in_r = 16'h0000;
    idle0 = '0; idle0.w = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_word("reset_state", actual(), idle0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed instructions.
    load_ir(16'hD007); exec(16'hD007, 1);
    load_ir(16'hD1FE); exec(16'hD1FE, 1);
    load_ir(16'hA148); exec(16'hA148, 1);
    load_ir(16'hA801); exec(16'hA801, 1);
    load_ir(16'hC070); exec(16'hC070, 1);

    // Load attempt during ADD is ignored; s held gives a second run of the same ADD.
    load_ir(16'hA148);
    expect_instr(16'hA148, len);
    expect_instr(16'hA148, len);
    s = 1'b1;
    @(posedge clk);
    #1 load = 1'b1; in_r = 16'hD0FF;
    repeat (3) @(posedge clk);
    #1 load = 1'b0;
    repeat (3) @(posedge clk);
    #1 s = 1'b0;
    wait_idle();
    @(posedge clk); #1;

    // Illegal encodings.
    load_ir(16'hE000); exec(16'hE000, 1);
    load_ir(16'hC800); exec(16'hC800, 1);

    // Reset during the ALU cycle of an ADD.
    load_ir(16'hA148);
    expect_instr(16'hA148, len);
    s = 1'b1;
    @(posedge clk);
    #1 s = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_bit("alu_loadc_before_reset", loadc, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    #1 check_word("async_reset_word", actual(), idle0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_bit("no_write_after_reset", write, 1'b0);
      check_bit("w_after_reset", w, 1'b1);
    end

    // Randomized instructions, sometimes executed back-to-back.
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 3));
      op3 = (r < 2) ? 3'b101 : (r == 2) ? 3'b110 : 3'($urandom);
      ir = {op3, 2'($urandom), 11'($urandom)};
      load_ir(ir);
      exec(ir, ($urandom_range(0, 3) == 0) ? 2 : 1);
    end

    repeat (3) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expect: got %0d pending words required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
